// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, per-boundary control-bundle bit offsets and the
// bubble constant for the pipe_stage_reg family of pipeline registers.
package pipe_pkg;

  // Default widths for a generic stage boundary.
  localparam int DATA_W_DEF = 64;
  localparam int CTRL_W_DEF = 13;
  localparam int PC_W_DEF   = 30;
  localparam int CNT_W_DEF  = 16;

  // Bubble control bundle: every control bit low, so nothing is written.
  localparam int CTRL_NOP = 0;

  // Pipeline boundaries a stage register can sit on.
  typedef enum logic [1:0] {
    BND_IFID  = 2'd0,
    BND_IDEX  = 2'd1,
    BND_EXMEM = 2'd2,
    BND_MEMWB = 2'd3
  } boundary_e;

  // EX/MEM control bundle layout.
  localparam int EXMEM_REGWR        = 0;
  localparam int EXMEM_MEMTOREG_LSB = 1;
  localparam int EXMEM_MEMTOREG_MSB = 2;
  localparam int EXMEM_MEMWR_LSB    = 3;
  localparam int EXMEM_MEMWR_MSB    = 5;
  localparam int EXMEM_BRANCH_LSB   = 6;
  localparam int EXMEM_BRANCH_MSB   = 8;
  localparam int EXMEM_JUMP_LSB     = 9;
  localparam int EXMEM_JUMP_MSB     = 10;
  localparam int EXMEM_CTRL_W       = 11;

  // ID/EX carries the EX/MEM bundle plus the execute-stage selects on top.
  localparam int IDEX_ALUSRC = EXMEM_CTRL_W;
  localparam int IDEX_REGDST = EXMEM_CTRL_W + 1;
  localparam int IDEX_CTRL_W = EXMEM_CTRL_W + 2;

  // MEM/WB only needs the write-back controls.
  localparam int MEMWB_REGWR        = 0;
  localparam int MEMWB_MEMTOREG_LSB = 1;
  localparam int MEMWB_MEMTOREG_MSB = 2;
  localparam int MEMWB_CTRL_W       = 3;

  // Control width to use for a given boundary (IF/ID carries no control).
  function automatic int ctrl_width(input boundary_e bnd);
    case (bnd)
      BND_IDEX:  return IDEX_CTRL_W;
      BND_EXMEM: return EXMEM_CTRL_W;
      BND_MEMWB: return MEMWB_CTRL_W;
      default:   return 1;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: one-entry holding slot used by pipe_stage_reg when the
// PIPE_SKID_EN build option is defined. It catches the item accepted while
// the main register is stalled so that in_ready can come from a flop.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int PC_W   = PC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [CTRL_W-1:0] wr_ctrl,
  input  logic [PC_W-1:0]   wr_pc,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl,
  output logic [PC_W-1:0]   pc
);

  // Occupancy flag: flush empties the slot, a write fills it, a read drains it.
  always_ff @(negedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values and simulation order cannot change the result.
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (wr_en) begin
      valid <= 1'b1;
    end else if (rd_en) begin
      valid <= 1'b0;
    end
  end

  // Payload capture on write.
  always_ff @(negedge clk) begin
    // NOTE: the payload is storage, not control; it is only ever consumed
    // while valid=1, so it is deliberately left out of the reset.
    if (wr_en) begin
      data <= wr_data;
      ctrl <= wr_ctrl;
      pc   <= wr_pc;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register carrying payload, PC
// and a control bundle, with synchronous flush (bubble insertion) and a
// saturating stall counter. State updates on the falling clock edge.
// Build option: define PIPE_SKID_EN to add a one-entry skid buffer that
// makes in_ready a registered signal; without it in_ready is combinational
// from out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int PC_W   = PC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [PC_W-1:0]   out_pc,
  input  logic              flush,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_NOP);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

  // The main register may take a new value when it is empty or its item
  // is leaving this edge.
  logic main_adv;
  assign main_adv = !out_valid || out_ready;

  // Next contents of the main register when it advances.
  logic              nxt_valid;
  logic [DATA_W-1:0] nxt_data;
  logic [CTRL_W-1:0] nxt_ctrl;
  logic [PC_W-1:0]   nxt_pc;

`ifdef PIPE_SKID_EN
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [PC_W-1:0]   skid_pc;
  logic              skid_wr;
  logic              skid_rd;

  // Ready comes straight from the skid flop, cutting the path from out_ready.
  assign in_ready = !skid_valid;
  // An accepted item parks in the skid only when the main register is held.
  assign skid_wr  = in_valid && in_ready && !main_adv;
  // The skid drains into the main register whenever the main register moves.
  assign skid_rd  = main_adv && skid_valid;

  pipe_skid_buf #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .PC_W   (PC_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .wr_en   (skid_wr),
    .rd_en   (skid_rd),
    .wr_data (in_data),
    .wr_ctrl (in_ctrl),
    .wr_pc   (in_pc),
    .valid   (skid_valid),
    .data    (skid_data),
    .ctrl    (skid_ctrl),
    .pc      (skid_pc)
  );
`else
  assign in_ready = main_adv;
`endif

  // Select the main-register source: upstream input, with an invalid input
  // turned into a bubble; in skid builds the older skid item goes first.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    nxt_valid = in_valid;
    nxt_data  = in_data;
    nxt_ctrl  = in_valid ? in_ctrl : CTRL_BUBBLE;
    nxt_pc    = in_pc;
`ifdef PIPE_SKID_EN
    if (skid_valid) begin
      nxt_valid = 1'b1;
      nxt_data  = skid_data;
      nxt_ctrl  = skid_ctrl;
      nxt_pc    = skid_pc;
    end
`endif
  end

  // Main register: flush kills the item (payload/PC hold), advance loads,
  // otherwise everything holds for a stall.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= CTRL_BUBBLE;
      out_pc    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= CTRL_BUBBLE;
    end else if (main_adv) begin
      out_valid <= nxt_valid;
      out_data  <= nxt_data;
      out_ctrl  <= nxt_ctrl;
      out_pc    <= nxt_pc;
    end
  end

  // Stall statistics: count held-valid edges, saturate, clear wins.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (clr_stats) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: self-checking bench for pipe_stage_reg. A queue-level
// model tracks which items sit in the stage and what the output shows.
module tb_pipe_stage_reg;

  localparam int DATA_W  = 64;
  localparam int CTRL_W  = 13;
  localparam int PC_W    = 30;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic [PC_W-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [PC_W-1:0]   out_pc;
  logic              flush;
  logic              clr_stats;
  logic [CNT_W-1:0]  stall_cnt;

  pipe_stage_reg #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .PC_W   (PC_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .out_pc    (out_pc),
    .flush     (flush),
    .clr_stats (clr_stats),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
    logic [PC_W-1:0]   p;
  } item_t;

  item_t             q[$];      // items currently held, oldest first
  logic [DATA_W-1:0] m_data;    // payload shown on out_data
  logic [PC_W-1:0]   m_pc;      // PC shown on out_pc
  int                m_cnt;     // stall count
  logic              pre_rdy_exp;
  logic              pre_rdy_dut;

  function automatic logic model_ready(input logic ordy);
    if (CAP == 1) return (q.size() == 0) || ordy;
    return q.size() < CAP;
  endfunction

  function automatic logic exp_valid();
    return q.size() > 0;
  endfunction

  function automatic logic [CTRL_W-1:0] exp_ctrl();
    if (q.size() > 0) return q[0].c;
    return '0;
  endfunction

  task automatic model_reset();
    q.delete();
    m_data = '0;
    m_pc   = '0;
    m_cnt  = 0;
  endtask

  // Drive one cycle of inputs, step through the falling edge, advance model.
  task automatic cycle(input logic iv, input logic [DATA_W-1:0] d,
                       input logic [CTRL_W-1:0] c, input logic [PC_W-1:0] p,
                       input logic ordy, input logic fl, input logic clr);
    item_t it;
    logic  rdy;
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    in_pc     = p;
    out_ready = ordy;
    flush     = fl;
    clr_stats = clr;
    #1;
    rdy         = model_ready(ordy);
    pre_rdy_exp = rdy;
    pre_rdy_dut = in_ready;
    @(negedge clk);
    #1;
    if (clr) m_cnt = 0;
    else if (q.size() > 0 && !ordy && m_cnt < CNT_MAX) m_cnt++;
    if (fl) begin
      q.delete();
    end else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (iv && rdy) begin
        it.d = d;
        it.c = c;
        it.p = p;
        q.push_back(it);
      end
      if (q.size() > 0) begin
        m_data = q[0].d;
        m_pc   = q[0].p;
      end else begin
        m_data = d;
        m_pc   = p;
      end
    end
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, '0, '0, '0, ordy, 1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 0; in_data = '0; in_ctrl = '0; in_pc = '0;
    out_ready = 0; flush = 0; clr_stats = 0;
    model_reset();
    #2;
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_ctrl !== '0 || out_pc !== '0 ||
        stall_cnt !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_init: valid=%b data=%h ctrl=%h pc=%h cnt=%0d rdy=%b, required all 0 and rdy=1",
               out_valid, out_data, out_ctrl, out_pc, stall_cnt, in_ready);
    end
    @(negedge clk); @(negedge clk); #1;
    rst_n = 1'b1;

    // Mid-stream: hold a valid item with stall_cnt=5, then reset between edges.
    cycle(1'b1, 64'hDEAD_BEEF_0000_0005, 13'h1ABC, 30'h1234, 1'b1, 1'b0, 1'b1);
    repeat (5) idle(1'b0);
    n_tests++;
    if (out_valid !== 1'b1 || stall_cnt !== 4'd5) begin
      n_fail++;
      $display("FAIL reset_precond: valid=%b cnt=%0d, required valid=1 cnt=5", out_valid, stall_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_ctrl !== '0 || out_pc !== '0 ||
        stall_cnt !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_async: valid=%b data=%h ctrl=%h pc=%h cnt=%0d rdy=%b, required all 0 and rdy=1",
               out_valid, out_data, out_ctrl, out_pc, stall_cnt, in_ready);
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_streaming();
    logic [DATA_W-1:0] vals [3];
    vals[0] = 64'hAAAA_0000_0000_0001;
    vals[1] = 64'hBBBB_0000_0000_0002;
    vals[2] = 64'hCCCC_0000_0000_0003;
    idle(1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, vals[i], 13'h0041 + 13'(i), 30'h100 + 30'(i), 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== vals[i] || stall_cnt !== '0) begin
        n_fail++;
        $display("FAIL stream_%0d: valid=%b data=%h cnt=%0d, required valid=1 data=%h cnt=0",
                 i, out_valid, out_data, stall_cnt, vals[i]);
      end
    end
    idle(1'b1);
  endtask

  task automatic test_stall();
    logic [DATA_W-1:0] b_val;
    logic [DATA_W-1:0] c_val;
    b_val = 64'h0000_0000_0000_0B0B;
    c_val = 64'h0000_0000_0000_0C0C;
    cycle(1'b1, 64'hA, 13'h1, 30'h1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, b_val, 13'h2, 30'h2, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, c_val, 13'h3, 30'h3, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (pre_rdy_dut !== pre_rdy_exp || out_data !== b_val || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: rdy=%b data=%h valid=%b, required rdy=%b data=%h valid=1",
                 i, pre_rdy_dut, out_data, out_valid, pre_rdy_exp, b_val);
      end
    end
    n_tests++;
    if (stall_cnt !== 4'd3) begin
      n_fail++;
      $display("FAIL stall_count: cnt=%0d, required 3", stall_cnt);
    end
    // Release: base build shows a bubble, skid build shows the parked C.
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      n_tests++;
      if (out_valid !== exp_valid() || out_data !== m_data || out_ctrl !== exp_ctrl()) begin
        n_fail++;
        $display("FAIL stall_release_%0d: valid=%b data=%h ctrl=%h, required valid=%b data=%h ctrl=%h",
                 i, out_valid, out_data, out_ctrl, exp_valid(), m_data, exp_ctrl());
      end
    end
  endtask

  task automatic test_flush();
    cycle(1'b1, 64'h1111_2222_3333_4444, 13'h1FFF, 30'h2AAA, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 64'h5555_6666_7777_8888, 13'h1FFF, 30'h3BBB, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h9999_AAAA_BBBB_CCCC, 13'h1F0F, 30'h0CCC, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== m_data) begin
      n_fail++;
      $display("FAIL flush: valid=%b ctrl=%h data=%h, required valid=0 ctrl=0 data=%h",
               out_valid, out_ctrl, out_data, m_data);
    end
    idle(1'b1);
    n_tests++;
    if (out_valid !== 1'b0 || out_ctrl !== '0) begin
      n_fail++;
      $display("FAIL flush_discard: valid=%b ctrl=%h, required valid=0 ctrl=0", out_valid, out_ctrl);
    end
  endtask

  task automatic test_bubble();
    idle(1'b1);
    cycle(1'b0, 64'h0BAD_F00D_0000_0001, 13'h00A5, 30'h0555, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== 64'h0BAD_F00D_0000_0001) begin
      n_fail++;
      $display("FAIL bubble: valid=%b ctrl=%h data=%h, required valid=0 ctrl=0 data=0badf00d00000001",
               out_valid, out_ctrl, out_data);
    end
  endtask

  task automatic test_saturation();
    cycle(1'b1, 64'h5A, 13'h5, 30'h5, 1'b1, 1'b0, 1'b1);
    repeat (20) idle(1'b0);
    n_tests++;
    if (stall_cnt !== 4'd15) begin
      n_fail++;
      $display("FAIL sat: cnt=%0d, required 15", stall_cnt);
    end
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (stall_cnt !== '0) begin
      n_fail++;
      $display("FAIL clr_wins: cnt=%0d, required 0", stall_cnt);
    end
    idle(1'b0);
    n_tests++;
    if (stall_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL count_after_clr: cnt=%0d, required 1", stall_cnt);
    end
    repeat (3) idle(1'b1);
  endtask

  task automatic test_random();
    logic              iv;
    logic              ordy;
    logic              fl;
    logic              clr;
    logic [DATA_W-1:0] d;
    for (int i = 0; i < 400; i++) begin
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      fl   = ($urandom_range(0, 19) == 0);
      clr  = ($urandom_range(0, 24) == 0);
      d    = {$urandom, $urandom};
      cycle(iv, d, 13'($urandom), 30'($urandom), ordy, fl, clr);
      n_tests++;
      if (pre_rdy_dut !== pre_rdy_exp) begin
        n_fail++;
        $display("FAIL rand_ready[%0d]: got %b, required %b", i, pre_rdy_dut, pre_rdy_exp);
      end
      n_tests++;
      if (out_valid !== exp_valid() || out_ctrl !== exp_ctrl()) begin
        n_fail++;
        $display("FAIL rand_valid_ctrl[%0d]: valid=%b ctrl=%h, required valid=%b ctrl=%h",
                 i, out_valid, out_ctrl, exp_valid(), exp_ctrl());
      end
      n_tests++;
      if (out_data !== m_data || out_pc !== m_pc) begin
        n_fail++;
        $display("FAIL rand_payload[%0d]: data=%h pc=%h, required data=%h pc=%h",
                 i, out_data, out_pc, m_data, m_pc);
      end
      n_tests++;
      if (stall_cnt !== CNT_W'(m_cnt)) begin
        n_fail++;
        $display("FAIL rand_cnt[%0d]: cnt=%0d, required %0d", i, stall_cnt, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_bubble();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
